// File: rtl/ace_trs_classifier.sv
// ACE request classifier: decodes AW/AR snoop/barrier/domain into BYPASS/SNOOP/BARRIER,
// registers each channel through a one-entry pipeline stage and counts delivered SNOOP requests.

module ace_trs_chan #(
  parameter int unsigned PayloadWidth = 32,
  parameter int unsigned CntWidth     = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [1:0]              class_i,
  input  logic [PayloadWidth-1:0] payload_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [1:0]              class_o,
  output logic [PayloadWidth-1:0] payload_o,
  output logic [CntWidth-1:0]     snoop_cnt_o
);

  localparam logic [1:0] ClsSnoop = 2'b01;

  typedef enum logic {Empty = 1'b0, Full = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              class_q;
  logic [PayloadWidth-1:0] payload_q;
  logic [CntWidth-1:0]     cnt_q, cnt_d;
  logic                    accept, handshake;

  assign accept    = valid_i && ready_o;
  assign handshake = valid_o && ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= Empty;
      class_q   <= 2'b00;
      payload_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        class_q   <= class_i;
        payload_q <= payload_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Empty:   if (valid_i) state_d = Full;
      Full:    if (ready_i && !valid_i) state_d = Empty;
      default: state_d = Empty;
    endcase
  end

  // Ready is forced high during reset so upstream never stalls on a block being flushed.
  always_comb begin
    valid_o   = (state_q == Full);
    ready_o   = !rst_ni || (state_q == Empty) || ready_i;
    class_o   = class_q;
    payload_o = payload_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (handshake && (class_q == ClsSnoop) && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
    end
  end

  assign snoop_cnt_o = cnt_q;

endmodule

module ace_trs_classifier #(
  parameter int unsigned PayloadWidth = 32,
  parameter int unsigned CntWidth     = 8,
  parameter bit          ForceBypass  = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [2:0]              aw_snoop_i,
  input  logic [1:0]              aw_bar_i,
  input  logic [1:0]              aw_domain_i,
  input  logic [PayloadWidth-1:0] aw_payload_i,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [1:0]              aw_class_o,
  output logic [PayloadWidth-1:0] aw_payload_o,
  output logic [CntWidth-1:0]     aw_snoop_cnt_o,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  input  logic [3:0]              ar_snoop_i,
  input  logic [1:0]              ar_bar_i,
  input  logic [1:0]              ar_domain_i,
  input  logic [PayloadWidth-1:0] ar_payload_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [1:0]              ar_class_o,
  output logic [PayloadWidth-1:0] ar_payload_o,
  output logic [CntWidth-1:0]     ar_snoop_cnt_o
);

  localparam logic [1:0] ClsBypass  = 2'b00;
  localparam logic [1:0] ClsSnoop   = 2'b01;
  localparam logic [1:0] ClsBarrier = 2'b10;

  logic [1:0] aw_cls, ar_cls;

  // WriteBack is non-coherent in any domain but System; WriteNoSnoop only in Non-shareable/System.
  always_comb begin
    aw_cls = ClsSnoop;
    if (aw_bar_i[0]) begin
      aw_cls = ClsBarrier;
    end else if (ForceBypass) begin
      aw_cls = ClsBypass;
    end else if ((aw_snoop_i == 3'b011 && aw_domain_i != 2'b11) ||
                 (aw_snoop_i == 3'b000 && (aw_domain_i == 2'b00 || aw_domain_i == 2'b11))) begin
      aw_cls = ClsBypass;
    end
  end

  always_comb begin
    ar_cls = ClsSnoop;
    if (ar_bar_i[0]) begin
      ar_cls = ClsBarrier;
    end else if (ForceBypass) begin
      ar_cls = ClsBypass;
    end else if (ar_snoop_i == 4'b0000 && (ar_domain_i == 2'b00 || ar_domain_i == 2'b11)) begin
      ar_cls = ClsBypass;
    end
  end

  ace_trs_chan #(.PayloadWidth(PayloadWidth), .CntWidth(CntWidth)) u_aw (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .valid_i     (aw_valid_i),
    .ready_o     (aw_ready_o),
    .class_i     (aw_cls),
    .payload_i   (aw_payload_i),
    .valid_o     (aw_valid_o),
    .ready_i     (aw_ready_i),
    .class_o     (aw_class_o),
    .payload_o   (aw_payload_o),
    .snoop_cnt_o (aw_snoop_cnt_o)
  );

  ace_trs_chan #(.PayloadWidth(PayloadWidth), .CntWidth(CntWidth)) u_ar (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .valid_i     (ar_valid_i),
    .ready_o     (ar_ready_o),
    .class_i     (ar_cls),
    .payload_i   (ar_payload_i),
    .valid_o     (ar_valid_o),
    .ready_i     (ar_ready_i),
    .class_o     (ar_class_o),
    .payload_o   (ar_payload_o),
    .snoop_cnt_o (ar_snoop_cnt_o)
  );

endmodule

// File: tb/tb_ace_trs_classifier.sv
// Directed bench for ace_trs_classifier: default, ForceBypass and narrow-counter instances share stimulus.

module tb_ace_trs_classifier;

    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          aw_valid, aw_rdy_in;
    logic [2:0]    aw_snoop;
    logic [1:0]    aw_bar, aw_dom;
    logic [PW-1:0] aw_pl;
    logic          ar_valid, ar_rdy_in;
    logic [3:0]    ar_snoop;
    logic [1:0]    ar_bar, ar_dom;
    logic [PW-1:0] ar_pl;

    logic          m_aw_rdy, m_aw_vld, m_ar_rdy, m_ar_vld;
    logic [1:0]    m_aw_cls, m_ar_cls;
    logic [PW-1:0] m_aw_pl, m_ar_pl;
    logic [7:0]    m_aw_cnt, m_ar_cnt;

    logic          f_aw_rdy, f_aw_vld, f_ar_rdy, f_ar_vld;
    logic [1:0]    f_aw_cls, f_ar_cls;
    logic [PW-1:0] f_aw_pl, f_ar_pl;
    logic [7:0]    f_aw_cnt, f_ar_cnt;

    logic          c_aw_rdy, c_aw_vld, c_ar_rdy, c_ar_vld;
    logic [1:0]    c_aw_cls, c_ar_cls;
    logic [PW-1:0] c_aw_pl, c_ar_pl;
    logic [1:0]    c_aw_cnt, c_ar_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ace_trs_classifier u_main (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .aw_valid_i(aw_valid), .aw_ready_o(m_aw_rdy), .aw_snoop_i(aw_snoop), .aw_bar_i(aw_bar),
        .aw_domain_i(aw_dom), .aw_payload_i(aw_pl), .aw_valid_o(m_aw_vld), .aw_ready_i(aw_rdy_in),
        .aw_class_o(m_aw_cls), .aw_payload_o(m_aw_pl), .aw_snoop_cnt_o(m_aw_cnt),
        .ar_valid_i(ar_valid), .ar_ready_o(m_ar_rdy), .ar_snoop_i(ar_snoop), .ar_bar_i(ar_bar),
        .ar_domain_i(ar_dom), .ar_payload_i(ar_pl), .ar_valid_o(m_ar_vld), .ar_ready_i(ar_rdy_in),
        .ar_class_o(m_ar_cls), .ar_payload_o(m_ar_pl), .ar_snoop_cnt_o(m_ar_cnt)
    );

    ace_trs_classifier #(.ForceBypass(1'b1)) u_fb (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .aw_valid_i(aw_valid), .aw_ready_o(f_aw_rdy), .aw_snoop_i(aw_snoop), .aw_bar_i(aw_bar),
        .aw_domain_i(aw_dom), .aw_payload_i(aw_pl), .aw_valid_o(f_aw_vld), .aw_ready_i(aw_rdy_in),
        .aw_class_o(f_aw_cls), .aw_payload_o(f_aw_pl), .aw_snoop_cnt_o(f_aw_cnt),
        .ar_valid_i(ar_valid), .ar_ready_o(f_ar_rdy), .ar_snoop_i(ar_snoop), .ar_bar_i(ar_bar),
        .ar_domain_i(ar_dom), .ar_payload_i(ar_pl), .ar_valid_o(f_ar_vld), .ar_ready_i(ar_rdy_in),
        .ar_class_o(f_ar_cls), .ar_payload_o(f_ar_pl), .ar_snoop_cnt_o(f_ar_cnt)
    );

    ace_trs_classifier #(.CntWidth(2)) u_c2 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .aw_valid_i(aw_valid), .aw_ready_o(c_aw_rdy), .aw_snoop_i(aw_snoop), .aw_bar_i(aw_bar),
        .aw_domain_i(aw_dom), .aw_payload_i(aw_pl), .aw_valid_o(c_aw_vld), .aw_ready_i(aw_rdy_in),
        .aw_class_o(c_aw_cls), .aw_payload_o(c_aw_pl), .aw_snoop_cnt_o(c_aw_cnt),
        .ar_valid_i(ar_valid), .ar_ready_o(c_ar_rdy), .ar_snoop_i(ar_snoop), .ar_bar_i(ar_bar),
        .ar_domain_i(ar_dom), .ar_payload_i(ar_pl), .ar_valid_o(c_ar_vld), .ar_ready_i(ar_rdy_in),
        .ar_class_o(c_ar_cls), .ar_payload_o(c_ar_pl), .ar_snoop_cnt_o(c_ar_cnt)
    );

    // Decode vectors: {snoop, bar, domain} -> expected class on the default instance.
    logic [2:0] aw_t_sn  [7] = '{3'b011, 3'b011, 3'b000, 3'b000, 3'b011, 3'b111, 3'b101};
    logic [1:0] aw_t_bar [7] = '{2'b00,  2'b00,  2'b00,  2'b00,  2'b10,  2'b01,  2'b00};
    logic [1:0] aw_t_dom [7] = '{2'b00,  2'b11,  2'b11,  2'b01,  2'b10,  2'b00,  2'b00};
    logic [1:0] aw_t_cls [7] = '{2'b00,  2'b01,  2'b00,  2'b01,  2'b00,  2'b10,  2'b01};
    logic [3:0] ar_t_sn  [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    logic [1:0] ar_t_bar [5] = '{2'b00,   2'b00,   2'b01,   2'b00,   2'b10};
    logic [1:0] ar_t_dom [5] = '{2'b00,   2'b01,   2'b11,   2'b11,   2'b11};
    logic [1:0] ar_t_cls [5] = '{2'b00,   2'b01,   2'b10,   2'b01,   2'b00};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0;
        aw_valid = 1'b0; aw_rdy_in = 1'b0; aw_snoop = '0; aw_bar = '0; aw_dom = '0; aw_pl = '0;
        ar_valid = 1'b0; ar_rdy_in = 1'b0; ar_snoop = '0; ar_bar = '0; ar_dom = '0; ar_pl = '0;

        // Reset state, with downstream not ready: upstream ready still forced high.
        tick(); tick();
        chk("rst_aw_ready", m_aw_rdy, 1'b1);
        chk("rst_ar_ready", m_ar_rdy, 1'b1);
        chk("rst_aw_valid", m_aw_vld, 1'b0);
        chk("rst_aw_class", m_aw_cls, 2'b00);
        chk("rst_aw_payload", m_aw_pl, 32'h0);
        chk("rst_ar_cnt", m_ar_cnt, 8'h0);
        rst_n = 1'b1; aw_rdy_in = 1'b1; ar_rdy_in = 1'b1;
        tick();

        // WriteBack in outer-shareable domain is BYPASS and does not count.
        aw_valid = 1'b1; aw_snoop = 3'b011; aw_bar = 2'b00; aw_dom = 2'b10; aw_pl = 32'hA1;
        tick();
        chk("wb_valid", m_aw_vld, 1'b1);
        chk("wb_class", m_aw_cls, 2'b00);
        chk("wb_payload", m_aw_pl, 32'hA1);
        chk("ar_idle", m_ar_vld, 1'b0);
        aw_valid = 1'b0;
        tick();
        chk("wb_cnt", m_aw_cnt, 8'd0);
        chk("wb_drained", m_aw_vld, 1'b0);

        // AR snoop request: SNOOP class, counter 0 -> 1 after handshake.
        ar_valid = 1'b1; ar_snoop = 4'b0001; ar_bar = 2'b00; ar_dom = 2'b01; ar_pl = 32'hB2;
        tick();
        chk("ar_snoop_class", m_ar_cls, 2'b01);
        chk("ar_cnt_before", m_ar_cnt, 8'd0);
        ar_valid = 1'b0;
        tick();
        chk("ar_cnt_after", m_ar_cnt, 8'd1);
        chk("aw_cnt_indep", m_aw_cnt, 8'd0);

        // Backpressure: hold downstream for 5 cycles with a second request waiting.
        aw_rdy_in = 1'b0;
        aw_valid = 1'b1; aw_snoop = 3'b000; aw_dom = 2'b00; aw_pl = 32'hC3;
        tick();
        aw_snoop = 3'b010; aw_dom = 2'b01; aw_pl = 32'hD4;
        #1;
        chk("bp_ready_low", m_aw_rdy, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", m_aw_vld, 1'b1);
            chk("bp_payload", m_aw_pl, 32'hC3);
            chk("bp_class", m_aw_cls, 2'b00);
            chk("bp_ready", m_aw_rdy, 1'b0);
        end
        aw_rdy_in = 1'b1;
        #1;
        chk("bp_ready_pass", m_aw_rdy, 1'b1);
        tick();
        chk("bp_second_valid", m_aw_vld, 1'b1);
        chk("bp_second_payload", m_aw_pl, 32'hD4);
        chk("bp_second_class", m_aw_cls, 2'b01);
        chk("bp_cnt_first", m_aw_cnt, 8'd0);
        aw_valid = 1'b0;
        tick();
        chk("bp_cnt_second", m_aw_cnt, 8'd1);
        chk("bp_drained", m_aw_vld, 1'b0);

        // ForceBypass: barrier stays BARRIER, snoop becomes BYPASS.
        aw_valid = 1'b1; aw_snoop = 3'b011; aw_bar = 2'b01; aw_dom = 2'b00; aw_pl = 32'hE5;
        tick();
        chk("fb_barrier", f_aw_cls, 2'b10);
        aw_snoop = 3'b001; aw_bar = 2'b00; aw_dom = 2'b01;
        tick();
        chk("fb_bypass", f_aw_cls, 2'b00);
        chk("nofb_snoop", m_aw_cls, 2'b01);
        aw_valid = 1'b0;
        tick();
        chk("fb_cnt", f_aw_cnt, 8'd0);

        // Narrow counter saturation, then clear winning over a concurrent increment.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_c2", c_aw_cnt, 2'd0);
        chk("clr_main", m_aw_cnt, 8'd0);
        aw_valid = 1'b1; aw_snoop = 3'b010; aw_bar = 2'b00; aw_dom = 2'b01;
        for (int i = 0; i < 5; i++) begin
            aw_pl = 32'h100 + i;
            tick();
        end
        aw_valid = 1'b0;
        tick();
        chk("sat_c2", c_aw_cnt, 2'd3);
        chk("sat_main", m_aw_cnt, 8'd5);
        aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_prio_c2", c_aw_cnt, 2'd0);
        chk("clr_prio_main", m_aw_cnt, 8'd0);
        tick();
        chk("clr_hold", c_aw_cnt, 2'd0);

        // Reset while FULL on both channels discards the held entries.
        aw_rdy_in = 1'b0; ar_rdy_in = 1'b0;
        aw_valid = 1'b1; aw_snoop = 3'b010; aw_pl = 32'hF6;
        ar_valid = 1'b1; ar_snoop = 4'b0010; ar_dom = 2'b01; ar_pl = 32'hF7;
        tick();
        aw_valid = 1'b0; ar_valid = 1'b0;
        chk("full_aw", m_aw_vld, 1'b1);
        chk("full_ar", m_ar_vld, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_full_ready", m_aw_rdy, 1'b1);
        tick();
        rst_n = 1'b1;
        chk("rst_full_aw_valid", m_aw_vld, 1'b0);
        chk("rst_full_ar_valid", m_ar_vld, 1'b0);
        chk("rst_full_ar_cnt", m_ar_cnt, 8'd0);
        chk("rst_full_payload", m_aw_pl, 32'h0);
        aw_rdy_in = 1'b1; ar_rdy_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_delivery", m_aw_vld, 1'b0);
            chk("no_delivery_cnt", m_aw_cnt, 8'd0);
        end

        // Decode tables, streamed back to back at full throughput.
        for (int i = 0; i < 7; i++) begin
            aw_valid = 1'b1; aw_snoop = aw_t_sn[i]; aw_bar = aw_t_bar[i]; aw_dom = aw_t_dom[i];
            aw_pl = 32'h200 + i;
            tick();
            chk("aw_decode", m_aw_cls, aw_t_cls[i]);
            chk("aw_stream_payload", m_aw_pl, 32'h200 + i);
        end
        aw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ar_valid = 1'b1; ar_snoop = ar_t_sn[i]; ar_bar = ar_t_bar[i]; ar_dom = ar_t_dom[i];
            ar_pl = 32'h300 + i;
            tick();
            chk("ar_decode", m_ar_cls, ar_t_cls[i]);
        end
        ar_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
